bg_scroll_tile_pipe: RTL and testbench
======================================

// Module: bg_scroll_tile_pipe
// PURPOSE
//  Parametrised background renderer core: frame-synchronous X/Y scroll control plus a pipelined
//  nametable -> attribute -> pattern fetch, producing one palette-indexed background pixel per clk.
//  Sits between the VGA driver position counters and the PPU mixer; the nametable, attribute and
//  pattern memories are external synchronous RAMs/ROMs with 1-cycle read latency.
// PARAMETERS
//  COORD_W    10   width of vga_pos_x/vga_pos_y
//  START_X    0    first game-window column;  START_Y 0  first game-window row
//  WIN_W      256  game-window width (px);    WIN_H   240 game-window height (px)
//  TILE_W     8    tile edge in px (power of 2)
//  MAP_COLS   32   nametable columns (power of 2);  MAP_ROWS 64  nametable rows (power of 2)
//  TILE_IDX_W 8    tile index width;  PIX_W 2  bits/pixel;  PAL_W 2  palette-select bits
// PORTS
//  clk           in   1                       pixel-pipeline clock
//  rst           in   1                       async, active-high reset
//  vga_pos_x     in   COORD_W                 current VGA column
//  vga_pos_y     in   COORD_W                 current VGA row
//  cfg_wr        in   1                       1-cycle strobe: capture cfg_* into shadow regs
//  cfg_mode      in   1                       0 = manual, 1 = auto-scroll
//  cfg_scroll_x  in   log2(MAP_COLS*TILE_W)   requested X scroll (px)
//  cfg_scroll_y  in   log2(MAP_ROWS*TILE_W)   requested Y scroll (px)
//  cfg_auto_div  in   8                       auto mode: frames per 1-px step (0 treated as 1)
//  cfg_pause     in   1                       level; freezes auto-scroll stepping
//  cfg_pending   out  1                       shadow written, not yet applied
//  frame_strobe  out  1                       1-cycle pulse at end of game window
//  scroll_y_cur  out  log2(MAP_ROWS*TILE_W)   active Y scroll (CPU readback)
//  nt_addr       out  log2(MAP_COLS*MAP_ROWS) nametable read address
//  nt_data       in   TILE_IDX_W              tile index, valid 1 clk after nt_addr
//  attr_addr     out  log2(MAP_COLS*MAP_ROWS/4) attribute address (one entry per 2x2 tiles)
//  attr_data     in   PAL_W+1                 [PAL_W-1:0] palette, [PAL_W] hflip; 1-clk latency
//  pat_addr      out  TILE_IDX_W+log2(TILE_W) {tile index, fine_y}
//  pat_data      in   TILE_W*PIX_W            pattern row, pixel 0 in MSBs; 1-clk latency
//  pix_out       out  PAL_W+PIX_W             {palette, pixel index}
//  pix_valid     out  1                       pix_out lies inside the game window
// BEHAVIOUR
//  Reset: every register and output 0; active scroll 0, mode manual, frame counter 0.
//  Frame strobe: register pos, flag (x==START_X+WIN_W-1 && y==START_Y+WIN_H-1), registered again;
//   frame_strobe = rising edge of the flag -> exactly one pulse per frame, 3 clk after the pos.
//  Config: cfg_wr loads shadow, sets cfg_pending. On frame_strobe, shadow -> active, pending clears,
//   frame counter clears. cfg_wr in the strobe cycle: new values applied immediately, pending stays 0.
//  Auto mode (active mode=1, pause=0): frame counter increments per strobe; on reaching
//   max(cfg_auto_div,1) it clears and scroll_y decrements by 1, wrapping 0 -> MAP_ROWS*TILE_W-1.
//   A pending load on the same strobe overrides the step. Pause holds both counter and scroll.
//  Pipeline (latency 4 clk, pos -> pix_out, one pixel/clk, no stalls):
//   S0 register pos, in_win = inside window; mx=(x-START_X+scroll_x) mod MAP_COLS*TILE_W,
//      my=(y-START_Y+scroll_y) mod MAP_ROWS*TILE_W (power-of-2 truncation)
//   S1 drive nt_addr=my_tile*MAP_COLS+mx_tile, attr_addr=(my_tile>>1)*(MAP_COLS/2)+(mx_tile>>1)
//   S2 nt_data/attr_data arrive; drive pat_addr={nt_data, fine_y}; carry attr, fine_x
//   S3 pat_data arrives; select pixel; S4 register pix_out/pix_valid
//  Outside window: pix_valid=0, pix_out=0. Active scroll changes only at frame_strobe -> no tearing.
//  Reset mid-frame: pipeline flushed, pix_valid 0 until 4 clk after first in-window pos.
// CONFIGURATION
//  BG_HFLIP_EN defined: attr_data[PAL_W]=1 mirrors the tile horizontally (fine_x -> TILE_W-1-fine_x).
//  Not defined: attr_data[PAL_W] ignored, no flip mux; port width unchanged.
// STRUCTURE
//  Package bg_draw_pkg: MODE_MANUAL/MODE_AUTO, PIPE_LAT=4, map-size and address-width localparams.
//  Sub-module bg_frame_sync: frame-strobe detect, shadow/active regs, auto-scroll counter.
// TESTING
//  1 assert rst mid-run -> all outputs 0 same cycle; cfg_pending 0; pix_valid 0 for 4 clk post-release
//  2 scroll 0, pos (0,0), nt_data=5, pat_data=16'h4000 -> nt_addr 0, pat_addr {5,0}, pix_out 2'b01 @+4
//  3 cfg_scroll_x=250, pos x=10 -> mx=4: nt_addr col 0, fine_x 4 (wrap-around)
//  4 cfg_wr scroll_y=16 mid-frame -> cfg_pending=1, scroll_y_cur 0 until frame_strobe, then 16
//  5 auto, div=2, scroll_y=0 -> after 2 strobes scroll_y_cur=511; pause=1 -> unchanged 3 frames
//  6 BG_HFLIP_EN, attr flip=1, fine_x=0, pat_data=16'h0003 -> pixel 2'b11 (off: 2'b00)

Source files
------------

// File: rtl/bg_draw_pkg.sv
// bg_draw_pkg: shared scroll modes, pipeline latency and default map geometry for the background renderer
package bg_draw_pkg;
  typedef enum logic {MODE_MANUAL = 1'b0, MODE_AUTO = 1'b1} scroll_mode_e;
  localparam int PIPE_LAT = 4;
  localparam int DEF_TILE_W = 8;
  localparam int DEF_MAP_COLS = 32;
  localparam int DEF_MAP_ROWS = 64;
  localparam int DEF_SX_W = $clog2(DEF_MAP_COLS * DEF_TILE_W);
  localparam int DEF_SY_W = $clog2(DEF_MAP_ROWS * DEF_TILE_W);
  localparam int DEF_NT_AW = $clog2(DEF_MAP_COLS * DEF_MAP_ROWS);
  localparam int DEF_AT_AW = $clog2(DEF_MAP_COLS * DEF_MAP_ROWS / 4);
endpackage

// File: rtl/bg_frame_sync.sv
// bg_frame_sync: end-of-window frame strobe, shadow/active scroll registers and auto-scroll stepping
module bg_frame_sync
  import bg_draw_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int WIN_W = 256,
  parameter int WIN_H = 240,
  parameter int SX_W = 8,
  parameter int SY_W = 9
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [COORD_W-1:0] vga_pos_x,
  input  logic [COORD_W-1:0] vga_pos_y,
  input  logic               cfg_wr,
  input  logic               cfg_mode,
  input  logic [SX_W-1:0]    cfg_scroll_x,
  input  logic [SY_W-1:0]    cfg_scroll_y,
  input  logic [7:0]         cfg_auto_div,
  input  logic               cfg_pause,
  output logic               frame_strobe,
  output logic               cfg_pending,
  output logic [SX_W-1:0]    scroll_x_cur,
  output logic [SY_W-1:0]    scroll_y_cur
);
  localparam logic [COORD_W-1:0] END_X = COORD_W'(START_X + WIN_W - 1);
  localparam logic [COORD_W-1:0] END_Y = COORD_W'(START_Y + WIN_H - 1);
  logic [COORD_W-1:0] px_q, py_q;
  logic flag_q, flag_qq;
  scroll_mode_e sh_mode, act_mode;
  logic [SX_W-1:0] sh_sx;
  logic [SY_W-1:0] sh_sy;
  logic [7:0] sh_div, act_div, frame_cnt;
  logic [8:0] cnt_inc;
  logic step;
  always_comb begin
    cnt_inc = {1'b0, frame_cnt} + 9'd1;
    step = cnt_inc >= {1'b0, (act_div == 8'd0) ? 8'd1 : act_div};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px_q <= '0;
      py_q <= '0;
      flag_q <= 1'b0;
      flag_qq <= 1'b0;
      frame_strobe <= 1'b0;
    end else begin
      px_q <= vga_pos_x;
      py_q <= vga_pos_y;
      flag_q <= (px_q == END_X) && (py_q == END_Y);
      flag_qq <= flag_q;
      frame_strobe <= flag_q & ~flag_qq;
    end
  end
  // a write landing on the strobe bypasses the shadow and takes effect this frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sh_mode <= MODE_MANUAL;
      sh_sx <= '0;
      sh_sy <= '0;
      sh_div <= '0;
      act_mode <= MODE_MANUAL;
      scroll_x_cur <= '0;
      scroll_y_cur <= '0;
      act_div <= '0;
      frame_cnt <= '0;
      cfg_pending <= 1'b0;
    end else begin
      if (cfg_wr) begin
        sh_mode <= scroll_mode_e'(cfg_mode);
        sh_sx <= cfg_scroll_x;
        sh_sy <= cfg_scroll_y;
        sh_div <= cfg_auto_div;
      end
      if (frame_strobe && cfg_wr) begin
        act_mode <= scroll_mode_e'(cfg_mode);
        scroll_x_cur <= cfg_scroll_x;
        scroll_y_cur <= cfg_scroll_y;
        act_div <= cfg_auto_div;
        frame_cnt <= '0;
        cfg_pending <= 1'b0;
      end else if (frame_strobe && cfg_pending) begin
        act_mode <= sh_mode;
        scroll_x_cur <= sh_sx;
        scroll_y_cur <= sh_sy;
        act_div <= sh_div;
        frame_cnt <= '0;
        cfg_pending <= 1'b0;
      end else begin
        if (cfg_wr) cfg_pending <= 1'b1;
        if (frame_strobe && act_mode == MODE_AUTO && !cfg_pause) begin
          frame_cnt <= step ? 8'd0 : cnt_inc[7:0];
          if (step) scroll_y_cur <= scroll_y_cur - 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/bg_scroll_tile_pipe.sv
// bg_scroll_tile_pipe: scrolled nametable/attribute/pattern fetch pipeline, one background pixel per clk.
// Define BG_HFLIP_EN to let attr_data[PAL_W] mirror a tile horizontally.
module bg_scroll_tile_pipe
  import bg_draw_pkg::*;
#(
  parameter int COORD_W = 10,
  parameter int START_X = 0,
  parameter int START_Y = 0,
  parameter int WIN_W = 256,
  parameter int WIN_H = 240,
  parameter int TILE_W = 8,
  parameter int MAP_COLS = 32,
  parameter int MAP_ROWS = 64,
  parameter int TILE_IDX_W = 8,
  parameter int PIX_W = 2,
  parameter int PAL_W = 2,
  localparam int SX_W = $clog2(MAP_COLS * TILE_W),
  localparam int SY_W = $clog2(MAP_ROWS * TILE_W),
  localparam int NT_AW = $clog2(MAP_COLS * MAP_ROWS),
  localparam int AT_AW = $clog2(MAP_COLS * MAP_ROWS / 4),
  localparam int FY_W = $clog2(TILE_W),
  localparam int ROW_W = TILE_W * PIX_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [COORD_W-1:0]     vga_pos_x,
  input  logic [COORD_W-1:0]     vga_pos_y,
  input  logic                   cfg_wr,
  input  logic                   cfg_mode,
  input  logic [SX_W-1:0]        cfg_scroll_x,
  input  logic [SY_W-1:0]        cfg_scroll_y,
  input  logic [7:0]             cfg_auto_div,
  input  logic                   cfg_pause,
  output logic                   cfg_pending,
  output logic                   frame_strobe,
  output logic [SY_W-1:0]        scroll_y_cur,
  output logic [NT_AW-1:0]       nt_addr,
  input  logic [TILE_IDX_W-1:0]  nt_data,
  output logic [AT_AW-1:0]       attr_addr,
  input  logic [PAL_W:0]         attr_data,
  output logic [TILE_IDX_W+FY_W-1:0] pat_addr,
  input  logic [ROW_W-1:0]       pat_data,
  output logic [PAL_W+PIX_W-1:0] pix_out,
  output logic                   pix_valid
);
  localparam logic [COORD_W:0] WW = (COORD_W + 1)'(WIN_W);
  localparam logic [COORD_W:0] WH = (COORD_W + 1)'(WIN_H);
  logic [SX_W-1:0] scroll_x_cur, mx_q;
  logic [SY_W-1:0] my_q;
  logic [COORD_W-1:0] rel_x, rel_y;
  logic [FY_W-1:0] fx1, fy1, fx2, fx_sel;
  logic [PAL_W-1:0] pal2;
  logic [ROW_W-1:0] row_sh;
  logic win0, win1, win2;
  bg_frame_sync #(
    .COORD_W(COORD_W), .START_X(START_X), .START_Y(START_Y), .WIN_W(WIN_W), .WIN_H(WIN_H),
    .SX_W(SX_W), .SY_W(SY_W)
  ) u_sync (
    .clk(clk), .rst(rst), .vga_pos_x(vga_pos_x), .vga_pos_y(vga_pos_y),
    .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_scroll_x(cfg_scroll_x), .cfg_scroll_y(cfg_scroll_y),
    .cfg_auto_div(cfg_auto_div), .cfg_pause(cfg_pause), .frame_strobe(frame_strobe),
    .cfg_pending(cfg_pending), .scroll_x_cur(scroll_x_cur), .scroll_y_cur(scroll_y_cur)
  );
  // map sizes are powers of 2, so row*COLS+col is a plain concatenation
  always_comb begin
    rel_x = vga_pos_x - COORD_W'(START_X);
    rel_y = vga_pos_y - COORD_W'(START_Y);
    nt_addr = {my_q[SY_W-1:FY_W], mx_q[SX_W-1:FY_W]};
    attr_addr = {my_q[SY_W-1:FY_W+1], mx_q[SX_W-1:FY_W+1]};
    pat_addr = {nt_data, fy1};
    row_sh = pat_data << (fx2 * PIX_W);
  end
`ifdef BG_HFLIP_EN
  assign fx_sel = attr_data[PAL_W] ? ~fx1 : fx1;
`else
  logic unused_hflip;
  assign unused_hflip = attr_data[PAL_W];
  assign fx_sel = fx1;
`endif
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mx_q <= '0;
      my_q <= '0;
      win0 <= 1'b0;
      fx1 <= '0;
      fy1 <= '0;
      win1 <= 1'b0;
      fx2 <= '0;
      pal2 <= '0;
      win2 <= 1'b0;
      pix_out <= '0;
      pix_valid <= 1'b0;
    end else begin
      mx_q <= rel_x[SX_W-1:0] + scroll_x_cur;
      my_q <= rel_y[SY_W-1:0] + scroll_y_cur;
      win0 <= ({1'b0, rel_x} < WW) && ({1'b0, rel_y} < WH);
      fx1 <= mx_q[FY_W-1:0];
      fy1 <= my_q[FY_W-1:0];
      win1 <= win0;
      fx2 <= fx_sel;
      pal2 <= attr_data[PAL_W-1:0];
      win2 <= win1;
      pix_out <= win2 ? {pal2, row_sh[ROW_W-1 -: PIX_W]} : '0;
      pix_valid <= win2;
    end
  end
endmodule

// File: tb/tb_bg_scroll_tile_pipe.sv
// tb_bg_scroll_tile_pipe: random-stimulus bench with a behavioural frame/pixel model and RAM models
module tb_bg_scroll_tile_pipe;
  import bg_draw_pkg::*;
  logic clk, rst;
  logic [9:0] vga_pos_x, vga_pos_y;
  logic cfg_wr, cfg_mode, cfg_pause;
  logic [7:0] cfg_scroll_x, cfg_auto_div;
  logic [8:0] cfg_scroll_y, scroll_y_cur;
  logic cfg_pending, frame_strobe, pix_valid;
  logic [10:0] nt_addr, pat_addr;
  logic [8:0] attr_addr;
  logic [7:0] nt_data;
  logic [2:0] attr_data;
  logic [15:0] pat_data;
  logic [3:0] pix_out;
  logic [7:0] nt_mem [2048];
  logic [2:0] at_mem [512];
  logic [15:0] pat_mem [2048];
  int checks = 0, errors = 0;
  int m_sx, m_sy, m_mode, m_div, m_cnt, m_pend, s_mode, s_sx, s_sy, s_div;
  bg_scroll_tile_pipe dut (
    .clk(clk), .rst(rst), .vga_pos_x(vga_pos_x), .vga_pos_y(vga_pos_y),
    .cfg_wr(cfg_wr), .cfg_mode(cfg_mode), .cfg_scroll_x(cfg_scroll_x), .cfg_scroll_y(cfg_scroll_y),
    .cfg_auto_div(cfg_auto_div), .cfg_pause(cfg_pause), .cfg_pending(cfg_pending),
    .frame_strobe(frame_strobe), .scroll_y_cur(scroll_y_cur), .nt_addr(nt_addr), .nt_data(nt_data),
    .attr_addr(attr_addr), .attr_data(attr_data), .pat_addr(pat_addr), .pat_data(pat_data),
    .pix_out(pix_out), .pix_valid(pix_valid)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    nt_data <= nt_mem[nt_addr];
    attr_data <= at_mem[attr_addr];
    pat_data <= pat_mem[pat_addr];
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic model_reset;
    m_sx = 0; m_sy = 0; m_mode = 0; m_div = 0; m_cnt = 0; m_pend = 0;
    s_mode = 0; s_sx = 0; s_sy = 0; s_div = 0;
  endtask
  function automatic int exp_nt(int x, int y);
    return (((y + m_sy) % 512) / 8) * 32 + ((x + m_sx) % 256) / 8;
  endfunction
  function automatic int exp_pix(int x, int y);
    int mx, my, t, a, fx, row;
    if (x >= 256 || y >= 240) return 0;
    mx = (x + m_sx) % 256;
    my = (y + m_sy) % 512;
    t = int'(nt_mem[exp_nt(x, y)]);
    a = int'(at_mem[(my / 16) * 16 + mx / 16]);
    fx = mx % 8;
`ifdef BG_HFLIP_EN
    if (a >= 4) fx = 7 - fx;
`endif
    row = int'(pat_mem[t * 8 + my % 8]);
    return (a % 4) * 4 + (row >> (2 * (7 - fx))) % 4;
  endfunction
  task automatic cfg(input int mode, input int sx, input int sy, input int div);
    cfg_mode = mode[0]; cfg_scroll_x = sx[7:0]; cfg_scroll_y = sy[8:0]; cfg_auto_div = div[7:0];
    cfg_wr = 1'b1;
    tick;
    cfg_wr = 1'b0;
    s_mode = mode; s_sx = sx; s_sy = sy; s_div = div; m_pend = 1;
    check("cfg_pending_set", cfg_pending, 1);
  endtask
  task automatic frame(input bit wr, input int mode, input int sx, input int sy, input int div);
    vga_pos_x = 10'd255; vga_pos_y = 10'd239;
    tick;
    vga_pos_x = 10'd0; vga_pos_y = 10'd0;
    check("strobe_e1", frame_strobe, 0);
    tick;
    check("strobe_e2", frame_strobe, 0);
    tick;
    check("strobe_e3", frame_strobe, 1);
    check("scroll_hold", scroll_y_cur, m_sy);
    if (wr) begin
      cfg_mode = mode[0]; cfg_scroll_x = sx[7:0]; cfg_scroll_y = sy[8:0]; cfg_auto_div = div[7:0];
      cfg_wr = 1'b1;
    end
    tick;
    cfg_wr = 1'b0;
    check("strobe_e4", frame_strobe, 0);
    if (wr) begin
      m_mode = mode; m_sx = sx; m_sy = sy; m_div = div; m_cnt = 0; m_pend = 0;
      s_mode = mode; s_sx = sx; s_sy = sy; s_div = div;
    end else if (m_pend != 0) begin
      m_mode = s_mode; m_sx = s_sx; m_sy = s_sy; m_div = s_div; m_cnt = 0; m_pend = 0;
    end else if (m_mode == 1 && !cfg_pause) begin
      m_cnt++;
      if (m_cnt >= ((m_div == 0) ? 1 : m_div)) begin
        m_cnt = 0;
        m_sy = (m_sy + 511) % 512;
      end
    end
    check("scroll_y", scroll_y_cur, m_sy);
    check("pending_after", cfg_pending, m_pend);
  endtask
  task automatic stream(input int n);
    int ex[$], ev[$];
    int x, y;
    for (int i = 0; i < n + PIPE_LAT - 1; i++) begin
      if (i < n) begin
        do begin
          x = $urandom_range(299, 0);
          y = $urandom_range(259, 0);
        end while (x == 255 && y == 239);
      end else begin
        x = 300; y = 0;
      end
      ex.push_back(exp_pix(x, y));
      ev.push_back((x < 256 && y < 240) ? 1 : 0);
      vga_pos_x = x[9:0]; vga_pos_y = y[9:0];
      tick;
      check("nt_addr", nt_addr, exp_nt(x, y));
      if (i >= PIPE_LAT - 1) begin
        check("pix_out", pix_out, ex[i-PIPE_LAT+1]);
        check("pix_valid", pix_valid, ev[i-PIPE_LAT+1]);
      end
    end
  endtask
  initial begin
    rst = 1'b1;
    vga_pos_x = '0; vga_pos_y = '0;
    cfg_wr = 0; cfg_mode = 0; cfg_pause = 0; cfg_scroll_x = '0; cfg_scroll_y = '0; cfg_auto_div = '0;
    for (int i = 0; i < 2048; i++) begin
      nt_mem[i] = 8'($urandom);
      pat_mem[i] = 16'($urandom);
    end
    for (int i = 0; i < 512; i++) at_mem[i] = 3'($urandom);
    model_reset;
    tick;
    tick;
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_out", pix_out, 0);
    check("rst_strobe", frame_strobe, 0);
    check("rst_pending", cfg_pending, 0);
    check("rst_scroll_y", scroll_y_cur, 0);
    rst = 1'b0;
    // horizontal wrap-around: x=10 with scroll 250 lands on column 0, fine_x 4
    cfg(0, 250, 0, 0);
    frame(0, 0, 0, 0, 0);
    nt_mem[0] = 8'd5; at_mem[0] = 3'd0; pat_mem[40] = 16'h4080;
    vga_pos_x = 10'd10; vga_pos_y = 10'd0;
    tick;
    check("wrap_nt_addr", nt_addr, 0);
    tick;
    tick;
    tick;
    check("wrap_pix", pix_out, 4'd2);
    stream(30);
    cfg(0, 0, 0, 0);
    stream(20);
    frame(0, 0, 0, 0, 0);
    // mid-run reset with a pending write and valid pixels in flight
    vga_pos_x = 10'd1; vga_pos_y = 10'd1;
    repeat (4) tick;
    check("pre_rst_valid", pix_valid, 1);
    cfg(0, 7, 7, 0);
    rst = 1'b1;
    #1;
    check("arst_pix_valid", pix_valid, 0);
    check("arst_pix_out", pix_out, 0);
    check("arst_pending", cfg_pending, 0);
    check("arst_scroll_y", scroll_y_cur, 0);
    check("arst_nt_addr", nt_addr, 0);
    model_reset;
    tick;
    rst = 1'b0;
    vga_pos_x = 10'd0; vga_pos_y = 10'd0;
    tick;
    check("post_nt_addr", nt_addr, 0);
    check("post_valid1", pix_valid, 0);
    tick;
    check("post_pat_addr", pat_addr, {8'd5, 3'd0});
    check("post_valid2", pix_valid, 0);
    tick;
    check("post_valid3", pix_valid, 0);
    tick;
    check("post_pix", pix_out, 4'b0001);
    check("post_valid4", pix_valid, 1);
    at_mem[0] = 3'b100; pat_mem[40] = 16'h0003;
    repeat (4) tick;
`ifdef BG_HFLIP_EN
    check("hflip_pix", pix_out, 4'b0011);
`else
    check("hflip_pix", pix_out, 4'b0000);
`endif
    cfg(0, 0, 16, 0);
    check("pend_scroll_old", scroll_y_cur, 0);
    stream(10);
    frame(0, 0, 0, 0, 0);
    stream(10);
    cfg(1, 0, 0, 2);
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    check("auto_wrap", scroll_y_cur, 511);
    cfg_pause = 1'b1;
    repeat (3) frame(0, 0, 0, 0, 0);
    check("pause_hold", scroll_y_cur, 511);
    cfg_pause = 1'b0;
    frame(0, 0, 0, 0, 0);
    frame(0, 0, 0, 0, 0);
    cfg(1, 3, 5, 0);
    repeat (3) frame(0, 0, 0, 0, 0);
    frame(1, 0, 100, 200, 0);
    stream(20);
    for (int r = 0; r < 8; r++) begin
      cfg(int'($urandom_range(1, 0)), int'($urandom_range(255, 0)), int'($urandom_range(511, 0)),
          int'($urandom_range(3, 0)));
      stream(20);
      frame(0, 0, 0, 0, 0);
      stream(20);
      cfg_pause = 1'($urandom);
      frame(r % 3 == 0, int'($urandom_range(1, 0)), int'($urandom_range(255, 0)),
            int'($urandom_range(511, 0)), int'($urandom_range(3, 0)));
      frame(0, 0, 0, 0, 0);
      stream(20);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
